// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Brief    : Opcodes, control-word bit map and microstep constants for the
//            8-bit CPU instruction-cycle controller.
// Revision : 1.0
// ============================================================================
package cpu_ctrl_pkg;

   localparam int STEP_W = 3;
   localparam int CW_W   = 12;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam int MI = 0;
   localparam int RI = 1;
   localparam int RO = 2;
   localparam int II = 3;
   localparam int IO = 4;
   localparam int AI = 5;
   localparam int AO = 6;
   localparam int EO = 7;
   localparam int SU = 8;
   localparam int BI = 9;
   localparam int OI = 10;
   localparam int FI = 11;

   localparam logic [STEP_W-1:0] T0 = 3'd0;
   localparam logic [STEP_W-1:0] T1 = 3'd1;
   localparam logic [STEP_W-1:0] T2 = 3'd2;
   localparam logic [STEP_W-1:0] T3 = 3'd3;
   localparam logic [STEP_W-1:0] T4 = 3'd4;

   // Final microstep that does useful work; undefined opcodes behave as NOP.
   function automatic logic [STEP_W-1:0] last_step_of(input logic [3:0] op);
      case (op)
         OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_step_of = T2;
         OP_LDA, OP_STA:                               last_step_of = T3;
         OP_ADD, OP_SUB:                               last_step_of = T4;
         default:                                      last_step_of = T1;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer_if
// Brief    : Opcode/flag inputs and PC/control-word outputs of the sequencer.
// Revision : 1.0
// ============================================================================
interface control_sequencer_if;
   import cpu_ctrl_pkg::*;

   logic [3:0]        opcode;
   logic              carry_flag;
   logic              zero_flag;
   logic              co_n;
   logic              ce;
   logic              j_n;
   logic [CW_W-1:0]   ctrl_word;
   logic              hlt;
   logic [STEP_W-1:0] step;

   modport master (
      input  opcode, carry_flag, zero_flag,
      output co_n, ce, j_n, ctrl_word, hlt, step
   );

   modport slave (
      output opcode, carry_flag, zero_flag,
      input  co_n, ce, j_n, ctrl_word, hlt, step
   );

endinterface
`default_nettype wire

// File: rtl/control_sequencer_microcode_rom.sv
`default_nettype none
// ============================================================================
// Module   : microcode_rom
// Brief    : Combinational decode of {opcode, step, flags} to control signals.
// Revision : 1.0
// ============================================================================
module microcode_rom
   import cpu_ctrl_pkg::*;
(
   input  wire logic [3:0]        opcode_i,
   input  wire logic [STEP_W-1:0] step_i,
   input  wire logic              carry_i,
   input  wire logic              zero_i,
   output logic [CW_W-1:0]        ctrl_word_o,
   output logic                   co_n_o,
   output logic                   ce_o,
   output logic                   j_n_o,
   output logic                   hlt_o,
   output logic                   last_step_o
);

   always_comb begin
      ctrl_word_o = '0;
      co_n_o      = 1'b1;
      ce_o        = 1'b0;
      j_n_o       = 1'b1;
      hlt_o       = 1'b0;
      case (step_i)
         T0: begin
            co_n_o          = 1'b0;
            ctrl_word_o[MI] = 1'b1;
         end
         T1: begin
            ctrl_word_o[RO] = 1'b1;
            ctrl_word_o[II] = 1'b1;
            ce_o            = 1'b1;
         end
         T2: begin
            case (opcode_i)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  ctrl_word_o[IO] = 1'b1;
                  ctrl_word_o[MI] = 1'b1;
               end
               OP_LDI: begin
                  ctrl_word_o[IO] = 1'b1;
                  ctrl_word_o[AI] = 1'b1;
               end
               OP_JMP: begin
                  ctrl_word_o[IO] = 1'b1;
                  j_n_o           = 1'b0;
               end
               // Conditional jumps look at the live flags, not a latched copy.
               OP_JC: begin
                  ctrl_word_o[IO] = carry_i;
                  j_n_o           = ~carry_i;
               end
               OP_JZ: begin
                  ctrl_word_o[IO] = zero_i;
                  j_n_o           = ~zero_i;
               end
               OP_OUT: begin
                  ctrl_word_o[AO] = 1'b1;
                  ctrl_word_o[OI] = 1'b1;
               end
               OP_HLT:  hlt_o = 1'b1;
               default: ;
            endcase
         end
         T3: begin
            case (opcode_i)
               OP_LDA: begin
                  ctrl_word_o[RO] = 1'b1;
                  ctrl_word_o[AI] = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  ctrl_word_o[RO] = 1'b1;
                  ctrl_word_o[BI] = 1'b1;
               end
               OP_STA: begin
                  ctrl_word_o[AO] = 1'b1;
                  ctrl_word_o[RI] = 1'b1;
               end
               default: ;
            endcase
         end
         T4: begin
            if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
               ctrl_word_o[EO] = 1'b1;
               ctrl_word_o[AI] = 1'b1;
               ctrl_word_o[FI] = 1'b1;
               ctrl_word_o[SU] = (opcode_i == OP_SUB);
            end
         end
         default: ;
      endcase
      last_step_o = (step_i == last_step_of(opcode_i));
   end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Brief    : Microstep counter, halt flag and reset masking around the ROM.
// Revision : 1.0
// ============================================================================
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int STEPS     = 5,
   parameter bit EARLY_END = 1'b1
) (
   input  wire logic            clk,
   input  wire logic            clr,
   control_sequencer_if.master  bus
);

   localparam logic [STEP_W-1:0] C_LAST_IDX = STEP_W'(STEPS - 1);

   logic [STEP_W-1:0] step_q, step_d;
   logic              halted_q, halted_d;

   logic [CW_W-1:0]   w_cw;
   logic              w_co_n, w_ce, w_j_n, w_hlt, w_last;

   microcode_rom u_rom (
      .opcode_i    (bus.opcode),
      .step_i      (step_q),
      .carry_i     (bus.carry_flag),
      .zero_i      (bus.zero_flag),
      .ctrl_word_o (w_cw),
      .co_n_o      (w_co_n),
      .ce_o        (w_ce),
      .j_n_o       (w_j_n),
      .hlt_o       (w_hlt),
      .last_step_o (w_last)
   );

   always_ff @(posedge clk) begin
      if (clr) begin
         step_q   <= T0;
         halted_q <= 1'b0;
      end else begin
         step_q   <= step_d;
         halted_q <= halted_d;
      end
   end

   // A halt freezes the counter on the HLT step itself.
   always_comb begin
      step_d   = step_q;
      halted_d = halted_q;
      if (!halted_q) begin
         if (w_hlt) begin
            halted_d = 1'b1;
         end else if (step_q == C_LAST_IDX || (EARLY_END && w_last)) begin
            step_d = T0;
         end else begin
            step_d = step_q + 3'd1;
         end
      end
   end

   always_comb begin
      bus.co_n      = 1'b1;
      bus.ce        = 1'b0;
      bus.j_n       = 1'b1;
      bus.ctrl_word = '0;
      bus.hlt       = 1'b0;
      if (clr) begin
         bus.hlt = 1'b0;
      end else if (halted_q) begin
         bus.hlt = 1'b1;
      end else begin
         bus.co_n      = w_co_n;
         bus.ce        = w_ce;
         bus.j_n       = w_j_n;
         bus.ctrl_word = w_cw;
         bus.hlt       = w_hlt;
      end
   end

   assign bus.step = step_q;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_sequencer
// Brief    : Directed and random checks of the instruction-cycle controller.
// Revision : 1.0
// ============================================================================
module tb_control_sequencer;
   import cpu_ctrl_pkg::*;

   logic clk;
   logic clr;
   int   n_vec;
   int   n_err;
   logic [11:0] drv_mask;

   control_sequencer_if bus ();

   control_sequencer #(
      .STEPS     (5),
      .EARLY_END (1'b1)
   ) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Packed view {step, co_n, ce, j_n, hlt, ctrl_word}
   task automatic expect_out(input string tag, input logic [2:0] s, input logic co,
                             input logic ce, input logic jn, input logic h,
                             input logic [11:0] cw);
      #1;
      chk(tag, {13'd0, bus.step, bus.co_n, bus.ce, bus.j_n, bus.hlt, bus.ctrl_word},
               {13'd0, s, co, ce, jn, h, cw});
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      drv_mask = 12'h0;
      drv_mask[RO] = 1'b1;
      drv_mask[IO] = 1'b1;
      drv_mask[AO] = 1'b1;
      drv_mask[EO] = 1'b1;

      clr = 1'b1;
      bus.opcode = 4'h0;
      bus.carry_flag = 1'b0;
      bus.zero_flag = 1'b0;

      // Reset and NOP
      tick();
      expect_out("reset_hold", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
      clr = 1'b0;
      expect_out("nop_t0", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h001);
      tick();
      expect_out("nop_t1", 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h00C);
      tick();
      expect_out("nop_wrap", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h001);

      // ADD
      bus.opcode = 4'h2;
      tick(); expect_out("add_t1", 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h00C);
      tick(); expect_out("add_t2", 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 12'h011);
      tick(); expect_out("add_t3", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 12'h204);
      tick(); expect_out("add_t4", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 12'h8A0);
      tick(); expect_out("add_wrap", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h001);

      // SUB
      bus.opcode = 4'h3;
      tick(); tick(); tick(); tick();
      expect_out("sub_t4", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 12'h9A0);
      tick(); expect_out("sub_wrap", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h001);

      // LDA ends after T3
      bus.opcode = 4'h1;
      tick(); tick(); tick();
      expect_out("lda_t3", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 12'h024);
      tick(); expect_out("lda_end", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h001);

      // STA
      bus.opcode = 4'h4;
      tick(); tick(); tick();
      expect_out("sta_t3", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 12'h042);
      tick();

      // LDI ends after T2
      bus.opcode = 4'h5;
      tick(); tick();
      expect_out("ldi_t2", 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 12'h030);
      tick(); expect_out("ldi_end", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h001);

      // OUT
      bus.opcode = 4'hE;
      tick(); tick();
      expect_out("out_t2", 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 12'h440);
      tick();

      // JMP
      bus.opcode = 4'h6;
      tick(); tick();
      expect_out("jmp_t2", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 12'h010);
      tick();

      // JC taken, then carry drops mid-T2
      bus.opcode = 4'h7;
      bus.carry_flag = 1'b1;
      tick(); tick();
      expect_out("jc_taken", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 12'h010);
      bus.carry_flag = 1'b0;
      expect_out("jc_not_taken", 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
      tick(); expect_out("jc_end", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h001);

      // JZ taken / not taken
      bus.opcode = 4'h8;
      bus.zero_flag = 1'b1;
      tick(); tick();
      expect_out("jz_taken", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 12'h010);
      bus.zero_flag = 1'b0;
      expect_out("jz_not_taken", 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
      tick();

      // Undefined opcode behaves as NOP
      bus.opcode = 4'hB;
      tick(); tick();
      expect_out("undef_end", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h001);

      // HLT
      bus.opcode = 4'hF;
      tick(); tick();
      expect_out("hlt_t2", 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000);
      for (int i = 0; i < 11; i++) begin
         tick();
         expect_out("halted", 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000);
      end
      clr = 1'b1;
      expect_out("halt_clr", 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
      tick();
      clr = 1'b0;
      bus.opcode = 4'h0;
      expect_out("halt_exit", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h001);

      // Reset during ADD T3
      bus.opcode = 4'h2;
      tick(); tick(); tick();
      expect_out("abort_t3", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 12'h204);
      clr = 1'b1;
      expect_out("abort_mask", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
      tick();
      clr = 1'b0;
      expect_out("abort_t0", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h001);

      // Random opcodes/flags, invariant checks
      for (int i = 0; i < 1000; i++) begin
         clr = (bus.hlt === 1'b1) || ($urandom_range(0, 31) == 0);
         bus.opcode = 4'($urandom_range(0, 15));
         bus.carry_flag = 1'($urandom_range(0, 1));
         bus.zero_flag = 1'($urandom_range(0, 1));
         #1;
         chk("inv_co_j", {31'd0, !(bus.co_n == 1'b0 && bus.j_n == 1'b0)}, 32'd1);
         chk("inv_bus", {31'd0, !(bus.co_n == 1'b0 && |(bus.ctrl_word & drv_mask))}, 32'd1);
         chk("inv_ce", {31'd0, !(bus.ce == 1'b1 && bus.step != 3'd1)}, 32'd1);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
